dram_device_model: RTL and testbench

// - Responder end of the dram_* command interface: decodes cs_n/ras_n/cas_n/we_n, keeps per-bank open-row state,

---
 rtl/dram_pkg.sv | 28 ++
 rtl/dram_bank_array.sv | 43 ++++
 rtl/dram_device_model.sv | 166 ++++++++++++++++
 tb/tb_dram_device_model.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared encodings for the dram_* command interface: command strobes, device FSM states and error codes.
package dram_pkg;

    // {ras_n, cas_n, we_n} with cs_n low
    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_REF = 3'b001;

    localparam logic [1:0] ST_INIT    = 2'd0;
    localparam logic [1:0] ST_READY   = 2'd1;
    localparam logic [1:0] ST_REFRESH = 2'd2;

    localparam logic [2:0] ERR_NONE         = 3'd0;
    localparam logic [2:0] ERR_NOT_INIT     = 3'd1;
    localparam logic [2:0] ERR_ACT_OPEN     = 3'd2;
    localparam logic [2:0] ERR_BANK_CLOSED  = 3'd3;
    localparam logic [2:0] ERR_REF_OPEN     = 3'd4;
    localparam logic [2:0] ERR_BUSY_REFRESH = 3'd5;
    localparam logic [2:0] ERR_BAD_CMD      = 3'd6;

    function automatic logic is_legal_cmd(input logic [2:0] cmd);
        return (cmd != 3'b000) && (cmd != 3'b110);
    endfunction

endpackage

// File: rtl/dram_bank_array.sv
// Banked storage behind the device model: one write port and one registered read port sharing a
// {bank, row, column} address; contents are deliberately left unreset.
module dram_bank_array #(
    parameter int DATA_WIDTH    = 2,
    parameter int BANK_ID_WIDTH = 3,
    parameter int ROW_WIDTH     = 7,
    parameter int COLUMN_WIDTH  = 2
) (
    input  logic                     u_clk,
    input  logic                     u_rst_n,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [BANK_ID_WIDTH-1:0] bank_id,
    input  logic [ROW_WIDTH-1:0]     row,
    input  logic [COLUMN_WIDTH-1:0]  col,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    localparam int ADDR_WIDTH = BANK_ID_WIDTH + ROW_WIDTH + COLUMN_WIDTH;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] addr;

    assign addr = {bank_id, row, col};

    always_ff @(posedge u_clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    // Read data holds its last value until the next accepted read
    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[addr];
        end
    end

endmodule

// File: rtl/dram_device_model.sv
// Responder end of the dram_* interface: command decode, init/refresh FSM, per-bank open-row
// tracking and protocol error reporting in front of a banked storage array.
module dram_device_model
    import dram_pkg::*;
#(
    parameter int NUMBER_OF_COLUMNS   = 8,
    parameter int NUMBER_OF_ROWS      = 128,
    parameter int NUMBER_OF_BANKS     = 8,
    parameter int DRAM_DATA_WIDTH     = 2,
    parameter int REFRESH_CYCLES      = 4,
    parameter int PRECHARGE_ALL       = 1,
    localparam int COLUMN_WIDTH       = $clog2(NUMBER_OF_COLUMNS / DRAM_DATA_WIDTH),
    localparam int ROW_WIDTH          = $clog2(NUMBER_OF_ROWS),
    localparam int BANK_ID_WIDTH      = $clog2(NUMBER_OF_BANKS),
    localparam int DRAM_ADDR_WIDTH    = (ROW_WIDTH > COLUMN_WIDTH) ? ROW_WIDTH : COLUMN_WIDTH
) (
    input  logic                       u_clk,
    input  logic                       u_rst_n,
    input  logic                       dram_cs_n,
    input  logic                       dram_ras_n,
    input  logic                       dram_cas_n,
    input  logic                       dram_we_n,
    input  logic                       dram_clk_en,
    input  logic [DRAM_ADDR_WIDTH-1:0] dram_addr,
    input  logic [BANK_ID_WIDTH-1:0]   dram_bank_id,
    input  logic [DRAM_DATA_WIDTH-1:0] dram_wr_data,
    output logic [DRAM_DATA_WIDTH-1:0] dram_rd_data,
    output logic                       dram_refresh_done,
    output logic                       init_done,
    output logic                       cmd_err,
    output logic [2:0]                 err_code
);

    localparam int TIMER_WIDTH = $clog2(REFRESH_CYCLES + 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LOAD = TIMER_WIDTH'(REFRESH_CYCLES - 1);

    logic [1:0]                 state;
    logic [TIMER_WIDTH-1:0]     timer;
    logic [NUMBER_OF_BANKS-1:0] bank_open;
    logic [ROW_WIDTH-1:0]       open_row [NUMBER_OF_BANKS];
    logic [2:0]                 cmd;
    logic                       cmd_valid;
    logic                       bank_is_open;
    logic [2:0]                 err_now;
    logic                       do_act, do_rd, do_wr, do_pre, do_ref;

    assign cmd          = {dram_ras_n, dram_cas_n, dram_we_n};
    assign cmd_valid    = !dram_cs_n && dram_clk_en;
    assign bank_is_open = bank_open[dram_bank_id];

    // Every rejected command raises exactly one error code and performs no action
    always_comb begin
        err_now = ERR_NONE;
        do_act  = 1'b0;
        do_rd   = 1'b0;
        do_wr   = 1'b0;
        do_pre  = 1'b0;
        do_ref  = 1'b0;
        if (cmd_valid && cmd != CMD_NOP) begin
            if (!is_legal_cmd(cmd)) begin
                err_now = ERR_BAD_CMD;
            end else begin
                case (state)
                    ST_INIT: begin
                        if (cmd == CMD_REF) do_ref = 1'b1;
                        else                err_now = ERR_NOT_INIT;
                    end
                    ST_READY: begin
                        case (cmd)
                            CMD_ACT: if (bank_is_open) err_now = ERR_ACT_OPEN;    else do_act = 1'b1;
                            CMD_RD:  if (!bank_is_open) err_now = ERR_BANK_CLOSED; else do_rd = 1'b1;
                            CMD_WR:  if (!bank_is_open) err_now = ERR_BANK_CLOSED; else do_wr = 1'b1;
                            CMD_PRE: do_pre = 1'b1;
                            CMD_REF: if (|bank_open) err_now = ERR_REF_OPEN;      else do_ref = 1'b1;
                            default: ;
                        endcase
                    end
                    ST_REFRESH: begin
                        if (cmd != CMD_REF) err_now = ERR_BUSY_REFRESH;
                    end
                    default: ;
                endcase
            end
        end
    end

    // The done cycle still counts as refreshing so a held REF is swallowed there too
    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            state             <= ST_INIT;
            timer             <= '0;
            dram_refresh_done <= 1'b0;
            init_done         <= 1'b0;
        end else begin
            dram_refresh_done <= 1'b0;
            case (state)
                ST_INIT, ST_READY: begin
                    if (do_ref) begin
                        state             <= ST_REFRESH;
                        timer             <= TIMER_LOAD;
                        dram_refresh_done <= (REFRESH_CYCLES == 1);
                    end
                end
                ST_REFRESH: begin
                    if (dram_refresh_done) begin
                        state     <= ST_READY;
                        init_done <= 1'b1;
                    end else if (dram_clk_en) begin
                        timer             <= timer - 1'b1;
                        dram_refresh_done <= (timer == TIMER_WIDTH'(1));
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            bank_open <= '0;
            for (int i = 0; i < NUMBER_OF_BANKS; i++) begin
                open_row[i] <= '0;
            end
        end else begin
            if (do_act) begin
                bank_open[dram_bank_id] <= 1'b1;
                open_row[dram_bank_id]  <= dram_addr[ROW_WIDTH-1:0];
            end
            if (do_pre) begin
                if (PRECHARGE_ALL != 0) bank_open <= '0;
                else                    bank_open[dram_bank_id] <= 1'b0;
            end
        end
    end

    // err_code keeps the first fault since reset; cmd_err flags each one
    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            cmd_err  <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            cmd_err <= (err_now != ERR_NONE);
            if (err_now != ERR_NONE && err_code == ERR_NONE) begin
                err_code <= err_now;
            end
        end
    end

    dram_bank_array #(
        .DATA_WIDTH   (DRAM_DATA_WIDTH),
        .BANK_ID_WIDTH(BANK_ID_WIDTH),
        .ROW_WIDTH    (ROW_WIDTH),
        .COLUMN_WIDTH (COLUMN_WIDTH)
    ) u_bank_array (
        .u_clk  (u_clk),
        .u_rst_n(u_rst_n),
        .wr_en  (do_wr),
        .rd_en  (do_rd),
        .bank_id(dram_bank_id),
        .row    (open_row[dram_bank_id]),
        .col    (dram_addr[COLUMN_WIDTH-1:0]),
        .wr_data(dram_wr_data),
        .rd_data(dram_rd_data)
    );

endmodule

// File: tb/tb_dram_device_model.sv
// Directed bench for dram_device_model with a cycle-level reference model checked every cycle.
module tb_dram_device_model;
    import dram_pkg::*;

    localparam int REFRESH_CYCLES = 4;

    logic       u_clk;
    logic       u_rst_n;
    logic       dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n, dram_clk_en;
    logic [6:0] dram_addr;
    logic [2:0] dram_bank_id;
    logic [1:0] dram_wr_data;
    logic [1:0] dram_rd_data;
    logic       dram_refresh_done, init_done, cmd_err;
    logic [2:0] err_code;

    int tests_run;
    int tests_failed;
    bit chk_on;

    // reference model state
    bit         m_open [8];
    int         m_row  [8];
    logic [1:0] m_mem  [int];
    bit         m_busy, m_ready;
    int         m_owed;
    logic [1:0] exp_rd;
    bit         exp_rd_known;
    bit         exp_done, exp_err, exp_init;
    logic [2:0] exp_code;

    dram_device_model dut (
        .u_clk            (u_clk),
        .u_rst_n          (u_rst_n),
        .dram_cs_n        (dram_cs_n),
        .dram_ras_n       (dram_ras_n),
        .dram_cas_n       (dram_cas_n),
        .dram_we_n        (dram_we_n),
        .dram_clk_en      (dram_clk_en),
        .dram_addr        (dram_addr),
        .dram_bank_id     (dram_bank_id),
        .dram_wr_data     (dram_wr_data),
        .dram_rd_data     (dram_rd_data),
        .dram_refresh_done(dram_refresh_done),
        .init_done        (init_done),
        .cmd_err          (cmd_err),
        .err_code         (err_code)
    );

    initial begin
        u_clk = 1'b0;
        forever #5 u_clk = ~u_clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) begin
            m_open[i] = 1'b0;
            m_row[i]  = 0;
        end
        m_busy       = 1'b0;
        m_ready      = 1'b0;
        m_owed       = 0;
        exp_rd       = 2'b00;
        exp_rd_known = 1'b1;
        exp_done     = 1'b0;
        exp_err      = 1'b0;
        exp_init     = 1'b0;
        exp_code     = 3'd0;
    endtask

    // Advances the model by one clock using the inputs presented during the cycle just ended
    task automatic modelStep();
        logic [2:0] c;
        int         err, b, key;
        bit         start, nxt_done, any_open;
        c        = {dram_ras_n, dram_cas_n, dram_we_n};
        b        = int'(dram_bank_id);
        err      = 0;
        start    = 1'b0;
        nxt_done = 1'b0;
        any_open = 1'b0;
        for (int i = 0; i < 8; i++) any_open |= m_open[i];
        if (!dram_cs_n && dram_clk_en && c != CMD_NOP) begin
            if (c == 3'b000 || c == 3'b110) begin
                err = 6;
            end else if (m_busy) begin
                if (c != CMD_REF) err = 5;
            end else if (!m_ready) begin
                if (c == CMD_REF) start = 1'b1;
                else              err = 1;
            end else begin
                key = b * 1024 + m_row[b] * 4 + int'(dram_addr[1:0]);
                case (c)
                    CMD_ACT: begin
                        if (m_open[b]) err = 2;
                        else begin
                            m_open[b] = 1'b1;
                            m_row[b]  = int'(dram_addr);
                        end
                    end
                    CMD_WR: begin
                        if (!m_open[b]) err = 3;
                        else m_mem[key] = dram_wr_data;
                    end
                    CMD_RD: begin
                        if (!m_open[b]) err = 3;
                        else if (m_mem.exists(key)) begin
                            exp_rd       = m_mem[key];
                            exp_rd_known = 1'b1;
                        end else begin
                            exp_rd_known = 1'b0;
                        end
                    end
                    CMD_PRE: begin
                        for (int i = 0; i < 8; i++) m_open[i] = 1'b0;
                    end
                    CMD_REF: begin
                        if (any_open) err = 4;
                        else start = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
        if (m_busy) begin
            if (exp_done) begin
                m_busy  = 1'b0;
                m_ready = 1'b1;
            end else if (dram_clk_en) begin
                m_owed--;
                nxt_done = (m_owed == 0);
            end
        end else if (start) begin
            m_busy   = 1'b1;
            m_owed   = REFRESH_CYCLES - 1;
            nxt_done = (m_owed == 0);
        end
        exp_done = nxt_done;
        exp_err  = (err != 0);
        exp_init = m_ready;
        if (err != 0 && exp_code == 3'd0) exp_code = 3'(err);
    endtask

    task automatic applyStimulus(input logic [2:0] c, input int bank, input int addr,
                                 input logic [1:0] wd, input bit en);
        dram_cs_n                          = 1'b0;
        {dram_ras_n, dram_cas_n, dram_we_n} = c;
        dram_clk_en                        = en;
        dram_bank_id                       = 3'(bank);
        dram_addr                          = 7'(addr);
        dram_wr_data                       = wd;
        @(posedge u_clk);
        modelStep();
        @(negedge u_clk);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) applyStimulus(CMD_NOP, 0, 0, 2'b00, 1'b1);
    endtask

    always @(negedge u_clk) begin
        if (u_rst_n && chk_on) begin
            checkOutput("model_refresh_done", {7'd0, dram_refresh_done}, {7'd0, exp_done});
            checkOutput("model_init_done", {7'd0, init_done}, {7'd0, exp_init});
            checkOutput("model_cmd_err", {7'd0, cmd_err}, {7'd0, exp_err});
            checkOutput("model_err_code", {5'd0, err_code}, {5'd0, exp_code});
            if (exp_rd_known) checkOutput("model_rd_data", {6'd0, dram_rd_data}, {6'd0, exp_rd});
        end
    end

    initial begin
        int pulses;
        tests_run    = 0;
        tests_failed = 0;
        chk_on       = 1'b0;
        dram_cs_n    = 1'b1;
        {dram_ras_n, dram_cas_n, dram_we_n} = CMD_NOP;
        dram_clk_en  = 1'b1;
        dram_addr    = '0;
        dram_bank_id = '0;
        dram_wr_data = '0;
        u_rst_n      = 1'b1;
        modelReset();
        #1 u_rst_n = 1'b0;
        #1;
        checkOutput("reset_rd_data", {6'd0, dram_rd_data}, 8'd0);
        checkOutput("reset_refresh_done", {7'd0, dram_refresh_done}, 8'd0);
        checkOutput("reset_init_done", {7'd0, init_done}, 8'd0);
        checkOutput("reset_cmd_err", {7'd0, cmd_err}, 8'd0);
        checkOutput("reset_err_code", {5'd0, err_code}, 8'd0);
        repeat (2) @(negedge u_clk);
        u_rst_n = 1'b1;
        chk_on  = 1'b1;

        // initial refresh: done exactly four cycles after accept
        applyStimulus(CMD_REF, 0, 0, 2'b00, 1'b1);
        nop(3);
        checkOutput("init_refresh_done_c4", {7'd0, dram_refresh_done}, 8'd1);
        nop(1);
        checkOutput("init_done_after_ref", {7'd0, init_done}, 8'd1);
        checkOutput("init_err_code_clean", {5'd0, err_code}, 8'd0);
        checkOutput("init_done_pulse_end", {7'd0, dram_refresh_done}, 8'd0);

        // write then read back
        applyStimulus(CMD_ACT, 2, 5, 2'b00, 1'b1);
        applyStimulus(CMD_WR, 2, 1, 2'b10, 1'b1);
        applyStimulus(CMD_RD, 2, 1, 2'b00, 1'b1);
        checkOutput("rd_b2r5c1", {6'd0, dram_rd_data}, 8'h02);

        // ACT on an already-open bank
        applyStimulus(CMD_ACT, 2, 9, 2'b00, 1'b1);
        checkOutput("act_open_cmd_err", {7'd0, cmd_err}, 8'd1);
        checkOutput("act_open_err_code", {5'd0, err_code}, 8'd2);
        applyStimulus(CMD_RD, 2, 1, 2'b00, 1'b1);
        checkOutput("rd_still_r5", {6'd0, dram_rd_data}, 8'h02);
        applyStimulus(CMD_WR, 2, 3, 2'b01, 1'b1);
        applyStimulus(CMD_RD, 2, 3, 2'b00, 1'b1);

        // read on a closed bank leaves rd_data and first error code alone
        applyStimulus(CMD_RD, 7, 0, 2'b00, 1'b1);
        checkOutput("rd_closed_cmd_err", {7'd0, cmd_err}, 8'd1);
        checkOutput("rd_closed_err_code", {5'd0, err_code}, 8'd2);
        checkOutput("rd_closed_hold", {6'd0, dram_rd_data}, 8'h01);

        // refresh with banks open is refused
        applyStimulus(CMD_ACT, 0, 3, 2'b00, 1'b1);
        applyStimulus(CMD_WR, 0, 2, 2'b11, 1'b1);
        applyStimulus(CMD_REF, 0, 0, 2'b00, 1'b1);
        checkOutput("ref_open_cmd_err", {7'd0, cmd_err}, 8'd1);
        nop(4);
        checkOutput("ref_open_no_done", {7'd0, dram_refresh_done}, 8'd0);

        // precharge-all then REF held through the done cycle
        applyStimulus(CMD_PRE, 0, 0, 2'b00, 1'b1);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(CMD_REF, 0, 0, 2'b00, 1'b1);
            if (dram_refresh_done) pulses++;
        end
        checkOutput("held_ref_single_pulse", 8'(pulses), 8'd1);
        checkOutput("held_ref_err_code", {5'd0, err_code}, 8'd2);
        applyStimulus(CMD_RD, 2, 1, 2'b00, 1'b1);
        checkOutput("pre_all_closed_b2", {7'd0, cmd_err}, 8'd1);

        // clock-enable low stretches refresh by two cycles
        applyStimulus(CMD_REF, 0, 0, 2'b00, 1'b1);
        applyStimulus(CMD_NOP, 0, 0, 2'b00, 1'b1);
        applyStimulus(CMD_NOP, 0, 0, 2'b00, 1'b0);
        applyStimulus(CMD_NOP, 0, 0, 2'b00, 1'b0);
        nop(2);
        checkOutput("clk_en_done_c6", {7'd0, dram_refresh_done}, 8'd1);
        nop(1);

        // array contents survive refresh
        applyStimulus(CMD_ACT, 0, 3, 2'b00, 1'b1);
        applyStimulus(CMD_RD, 0, 2, 2'b00, 1'b1);
        checkOutput("rd_b0r3c2", {6'd0, dram_rd_data}, 8'h03);

        // illegal encodings
        applyStimulus(3'b000, 0, 0, 2'b00, 1'b1);
        checkOutput("bad_cmd_000", {7'd0, cmd_err}, 8'd1);
        applyStimulus(3'b110, 0, 0, 2'b00, 1'b1);
        checkOutput("bad_cmd_110", {7'd0, cmd_err}, 8'd1);
        checkOutput("bad_cmd_code_kept", {5'd0, err_code}, 8'd2);
        applyStimulus(CMD_PRE, 0, 0, 2'b00, 1'b1);

        // reset in the middle of a refresh
        applyStimulus(CMD_REF, 0, 0, 2'b00, 1'b1);
        applyStimulus(CMD_NOP, 0, 0, 2'b00, 1'b1);
        u_rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("midref_rst_init", {7'd0, init_done}, 8'd0);
        checkOutput("midref_rst_done", {7'd0, dram_refresh_done}, 8'd0);
        repeat (2) @(negedge u_clk);
        u_rst_n = 1'b1;
        nop(5);
        checkOutput("midref_still_uninit", {7'd0, init_done}, 8'd0);
        applyStimulus(CMD_RD, 0, 0, 2'b00, 1'b1);
        checkOutput("rd_before_ref_err", {7'd0, cmd_err}, 8'd1);
        checkOutput("rd_before_ref_code", {5'd0, err_code}, 8'd1);
        nop(1);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
